// File: rtl/tmr_fsm_pkg.sv
// Shared encodings for the triplicated debounce FSM: state codes, copy count,
// qualifier counter width and the inj_copy code that disables injection.
package tmr_fsm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        QUAL_HI = 2'b01,
        ACTIVE  = 2'b11,
        QUAL_LO = 2'b10
    } state_t;

    localparam int NUM_COPIES = 3;
    localparam int CNT_W      = 8;

    localparam logic [1:0] INJ_NOP = 2'd3;

endpackage

// File: rtl/tmr_voter.sv
// Bitwise 2-of-3 majority voter; also flags any disagreement between the copies.
module tmr_voter #(
    parameter int W = 2
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] voted,
    output logic         mismatch
);

    assign voted    = (a & b) | (a & c) | (b & c);
    assign mismatch = (a != b) || (a != c);

endmodule

// File: rtl/voted_debounce_fsm.sv
// Per-channel debouncer whose 2-bit state is held in three scrubbed copies,
// with single-copy fault injection and a saturating copy-mismatch counter.
module voted_debounce_fsm
    import tmr_fsm_pkg::*;
#(
    parameter  int WIDTH = 4,
    parameter  int HOLD  = 3,
    parameter  int ERR_W = 8,
    localparam int CH_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic             inj_valid,
    input  logic [CH_W-1:0]  inj_ch,
    input  logic [1:0]       inj_copy,
    input  logic             clr_err,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count
);

    logic [WIDTH-1:0] ch_mismatch;
    logic             mismatch;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        logic [1:0]       copy_q [NUM_COPIES];
        logic [1:0]       voted;
        logic             ch_mis;
        state_t           cur_st;
        state_t           nxt_st;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] nxt_cnt;
        logic             rise_q;
        logic             inj_hit;

        tmr_voter #(.W(2)) u_voter (
            .a        (copy_q[0]),
            .b        (copy_q[1]),
            .c        (copy_q[2]),
            .voted    (voted),
            .mismatch (ch_mis)
        );

        assign cur_st  = state_t'(voted);
        // Channel match also covers out-of-range inj_ch, since no channel carries that index.
        assign inj_hit = inj_valid && (inj_ch == CH_W'(i)) && (inj_copy != INJ_NOP);

        always_comb begin
            nxt_st  = cur_st;
            nxt_cnt = cnt_q;
            case (cur_st)
                IDLE: begin
                    if (in[i]) begin
                        nxt_st  = QUAL_HI;
                        nxt_cnt = CNT_W'(1);
                    end
                end
                QUAL_HI: begin
                    if (!in[i]) begin
                        nxt_st  = IDLE;
                        nxt_cnt = '0;
                    end else if (cnt_q == CNT_W'(HOLD - 1)) begin
                        nxt_st  = ACTIVE;
                        nxt_cnt = '0;
                    end else begin
                        nxt_cnt = cnt_q + CNT_W'(1);
                    end
                end
                ACTIVE: begin
                    if (!in[i]) begin
                        nxt_st  = QUAL_LO;
                        nxt_cnt = CNT_W'(1);
                    end
                end
                QUAL_LO: begin
                    if (in[i]) begin
                        nxt_st  = ACTIVE;
                        nxt_cnt = '0;
                    end else if (cnt_q == CNT_W'(HOLD - 1)) begin
                        nxt_st  = IDLE;
                        nxt_cnt = '0;
                    end else begin
                        nxt_cnt = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    nxt_st  = IDLE;
                    nxt_cnt = '0;
                end
            endcase
        end

        // Every copy is rewritten from the voted next state each cycle, so a lone upset heals in one clock.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int c = 0; c < NUM_COPIES; c++) begin
                    copy_q[c] <= IDLE;
                end
                cnt_q  <= '0;
                rise_q <= 1'b0;
            end else begin
                for (int c = 0; c < NUM_COPIES; c++) begin
                    copy_q[c] <= (inj_hit && (inj_copy == 2'(c))) ? ~nxt_st : nxt_st;
                end
                cnt_q  <= nxt_cnt;
                rise_q <= (cur_st == QUAL_HI) && (nxt_st == ACTIVE);
            end
        end

        assign data_out[i]    = voted[1];
        assign rise_pulse[i]  = rise_q;
        assign ch_mismatch[i] = ch_mis;
    end

    assign mismatch = |ch_mismatch;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            err_pulse <= mismatch;
            if (clr_err) begin
                err_count <= '0;
            end else if (mismatch && (err_count != '1)) begin
                err_count <= err_count + ERR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_voted_debounce_fsm.sv
// Scoreboard bench: a driver updates a run-length model of each channel and
// queues the expected outputs; a monitor pops and compares after every edge.
module tb_voted_debounce_fsm;

    localparam int WIDTH = 4;
    localparam int HOLD  = 3;
    localparam int ERR_W = 2;

    typedef struct {
        logic [WIDTH-1:0] d;
        logic [WIDTH-1:0] r;
        logic             ep;
        logic [ERR_W-1:0] ec;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] in = '0;
    logic             inj_valid = 1'b0;
    logic [1:0]       inj_ch = '0;
    logic [1:0]       inj_copy = 2'd3;
    logic             clr_err = 1'b0;
    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] rise_pulse;
    logic             err_pulse;
    logic [ERR_W-1:0] err_count;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    bit   done = 1'b0;

    // Reference model state: qualified level plus length of the current run disagreeing with it.
    int   m_level [WIDTH];
    int   m_run   [WIDTH];
    int   m_cnt = 0;
    bit   m_pending = 1'b0;

    voted_debounce_fsm #(.WIDTH(WIDTH), .HOLD(HOLD), .ERR_W(ERR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in         (in),
        .inj_valid  (inj_valid),
        .inj_ch     (inj_ch),
        .inj_copy   (inj_copy),
        .clr_err    (clr_err),
        .data_out   (data_out),
        .rise_pulse (rise_pulse),
        .err_pulse  (err_pulse),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [WIDTH-1:0] v_in, input bit v_rst,
                                 input bit v_inj, input int v_ch, input int v_copy,
                                 input bit v_clr);
        exp_t e;
        @(negedge clk);
        in        = v_in;
        rst       = v_rst;
        inj_valid = v_inj;
        inj_ch    = 2'(v_ch);
        inj_copy  = 2'(v_copy);
        clr_err   = v_clr;
        e.r = '0;
        if (v_rst) begin
            for (int i = 0; i < WIDTH; i++) begin
                m_level[i] = 0;
                m_run[i]   = 0;
            end
            m_cnt     = 0;
            m_pending = 1'b0;
            e.ep      = 1'b0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (int'(v_in[i]) != m_level[i]) begin
                    m_run[i]++;
                    if (m_run[i] == HOLD) begin
                        m_level[i] = 1 - m_level[i];
                        m_run[i]   = 0;
                        e.r[i]     = (m_level[i] == 1);
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            e.ep = m_pending;
            if (v_clr) m_cnt = 0;
            else if (m_pending && m_cnt < (1 << ERR_W) - 1) m_cnt++;
            m_pending = v_inj && (v_copy != 3) && (v_ch < WIDTH);
        end
        for (int i = 0; i < WIDTH; i++) e.d[i] = (m_level[i] == 1);
        e.ec = ERR_W'(m_cnt);
        exp_q.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        n_cmp++;
        if (data_out !== e.d) begin
            n_bad++;
            $display("[TB] FAIL data_out cyc %0d: got %b expected %b", cyc, data_out, e.d);
        end
        n_cmp++;
        if (rise_pulse !== e.r) begin
            n_bad++;
            $display("[TB] FAIL rise_pulse cyc %0d: got %b expected %b", cyc, rise_pulse, e.r);
        end
        n_cmp++;
        if (err_pulse !== e.ep) begin
            n_bad++;
            $display("[TB] FAIL err_pulse cyc %0d: got %b expected %b", cyc, err_pulse, e.ep);
        end
        n_cmp++;
        if (err_count !== e.ec) begin
            n_bad++;
            $display("[TB] FAIL err_count cyc %0d: got %0d expected %0d", cyc, err_count, e.ec);
        end
    endtask

    initial begin : monitor
        exp_t e;
        while (!done) begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin : driver
        logic [WIDTH-1:0] raw;
        applyStimulus(4'b0000, 1, 0, 0, 3, 0);
        applyStimulus(4'b0000, 0, 0, 0, 3, 0);
        // ch0 qualifies after three highs; ch1 drops out after two
        repeat (2) applyStimulus(4'b0011, 0, 0, 0, 3, 0);
        applyStimulus(4'b0001, 0, 0, 0, 3, 0);
        repeat (2) applyStimulus(4'b0001, 0, 0, 0, 3, 0);
        // ch2 to ACTIVE, then a one-sample low glitch
        repeat (3) applyStimulus(4'b0101, 0, 0, 0, 3, 0);
        applyStimulus(4'b0001, 0, 0, 0, 3, 0);
        repeat (3) applyStimulus(4'b0101, 0, 0, 0, 3, 0);
        // single injection, then a no-op copy code
        applyStimulus(4'b0101, 0, 1, 3, 1, 0);
        repeat (2) applyStimulus(4'b0101, 0, 0, 0, 3, 0);
        applyStimulus(4'b0101, 0, 1, 2, 3, 0);
        repeat (2) applyStimulus(4'b0101, 0, 0, 0, 3, 0);
        // saturation with ERR_W=2, then clear racing an increment
        for (int k = 0; k < 5; k++) applyStimulus(4'b0101, 0, 1, k % WIDTH, k % 3, 0);
        applyStimulus(4'b0101, 0, 0, 0, 3, 0);
        applyStimulus(4'b0101, 0, 1, 1, 0, 0);
        applyStimulus(4'b0101, 0, 0, 0, 3, 1);
        applyStimulus(4'b0101, 0, 0, 0, 3, 0);
        // reset mid-qualification on ch0 with injection and clear pending
        repeat (4) applyStimulus(4'b0000, 0, 0, 0, 3, 0);
        repeat (2) applyStimulus(4'b0001, 0, 0, 0, 3, 0);
        applyStimulus(4'b0001, 1, 1, 0, 0, 1);
        repeat (4) applyStimulus(4'b0001, 0, 0, 0, 3, 0);
        raw = '0;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < WIDTH; i++) begin
                if ($urandom_range(0, 3) == 0) raw[i] = ~raw[i];
            end
            applyStimulus(raw, ($urandom_range(0, 79) == 0),
                          ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 3)), ($urandom_range(0, 15) == 0));
        end
        repeat (3) @(posedge clk);
        done = 1'b1;
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/voted_debounce_fsm.md
VOTED_DEBOUNCE_FSM -- requirements
Module: voted_debounce_fsm

Interface
REQ-001 Parameter WIDTH, default 4, number of independent input channels (1..32).
REQ-002 Parameter HOLD, default 3, consecutive samples needed to change a channel's qualified level (2..255).
REQ-003 Parameter ERR_W, default 8, width of the error counter.
REQ-004 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  synchronous, active-high reset.
REQ-006 Port in  input  WIDTH  raw per-channel inputs, sampled every clk edge.
REQ-007 Port inj_valid  input  1  fault-injection strobe, one cycle.
REQ-008 Port inj_ch  input  clog2(WIDTH) (min 1)  channel targeted by the injection.
REQ-009 Port inj_copy  input  2  state copy targeted by the injection (0..2; 3 = no-op).
REQ-010 Port clr_err  input  1  clears err_count.
REQ-011 Port data_out  output  WIDTH  qualified (debounced) level per channel.
REQ-012 Port rise_pulse  output  WIDTH  one-cycle pulse per channel on each qualified rising edge.
REQ-013 Port err_pulse  output  1  one-cycle flag: a copy mismatch was present in the previous cycle.
REQ-014 Port err_count  output  ERR_W  saturating count of cycles with a copy mismatch.

Function
REQ-015 Each channel SHALL hold its 2-bit FSM state in three copies (A, B, C); the effective state is the bitwise 2-of-3 majority.
REQ-016 States: IDLE=00, QUAL_HI=01, ACTIVE=11, QUAL_LO=10; each channel SHALL have a non-triplicated qualifier counter cnt, 8 bits wide.
REQ-017 IDLE: in=1 -> QUAL_HI with cnt=1; otherwise remain in IDLE.
REQ-018 QUAL_HI: in=0 -> IDLE; in=1 with cnt==HOLD-1 -> ACTIVE; in=1 otherwise -> cnt+1.
REQ-019 ACTIVE: in=0 -> QUAL_LO with cnt=1; otherwise remain in ACTIVE.
REQ-020 QUAL_LO: in=1 -> ACTIVE; in=0 with cnt==HOLD-1 -> IDLE; in=0 otherwise -> cnt+1.
REQ-021 Next state SHALL be computed from the voted state and written to all three copies every cycle (scrubbing).
REQ-022 data_out[i] SHALL be 1 when the voted state is ACTIVE or QUAL_LO, and SHALL be decoded directly from registers.
REQ-023 Latency: if in[i] is 1 for HOLD consecutive edges starting at edge k, data_out[i] SHALL rise after edge k+HOLD-1. Falling latency is symmetric.
REQ-024 rise_pulse[i] SHALL be registered and high for exactly the cycle following the QUAL_HI->ACTIVE transition edge; QUAL_LO->ACTIVE SHALL NOT pulse.
REQ-025 inj_valid=1 SHALL write the bitwise inverse of the computed next state into copy inj_copy of channel inj_ch only; the other copies receive the normal value.
REQ-026 Injection with inj_copy==3 or inj_ch>=WIDTH SHALL be ignored.
REQ-027 Mismatch SHALL be asserted when any channel has a copy differing from the others; err_pulse SHALL be the registered mismatch.
REQ-028 err_count SHALL increment by 1 on each mismatch cycle and saturate at all-ones.
REQ-029 clr_err SHALL set err_count to 0 and SHALL win over a simultaneous increment.
REQ-030 A single-copy fault SHALL NOT affect data_out, rise_pulse or cnt.

Reset
REQ-031 On rst=1 at an edge, all copies SHALL go to IDLE, cnt to 0, and data_out, rise_pulse, err_pulse and err_count to 0.
REQ-032 rst SHALL override inj_valid and clr_err, and SHALL abort any qualification mid-count.

Structure
REQ-033 State encodings, copy count (3) and the inj_copy no-op code SHALL reside in shared package tmr_fsm_pkg.
REQ-034 The majority function SHALL be the sub-module tmr_voter, parametrised on width and instantiated per channel.

Verification
REQ-035 WIDTH=4, HOLD=3: in[0]=1 for 3 edges -> data_out[0]=1 after the 3rd edge; rise_pulse[0]=1 for one cycle.
REQ-036 in[1]=1 for 2 edges then 0 -> data_out[1] stays 0; channel returns to IDLE; no rise_pulse.
REQ-037 ch2 ACTIVE; in[2]=0 for 1 edge then 1 -> data_out[2] stays 1; no rise_pulse.
REQ-038 inj_valid, inj_ch=3, inj_copy=1 -> data_out unchanged; err_pulse=1 the next cycle; err_count 0->1; the copies agree again one cycle later.
REQ-039 ERR_W=2, 5 injections -> err_count saturates at 3; clr_err together with an injection -> err_count=0.
REQ-040 rst asserted mid-QUAL_HI on ch0 -> all outputs 0; a fresh run of 3 high samples is needed to qualify.
